// File: rtl/tdm_demux_acc.sv
// tdm_demux_acc: realigns a round-robin TDM product stream to its source
// channel with a delayed slot tag, de-interleaves it into per-channel
// registers and sums fixed-length bursts per channel with saturation.
//
// Output handshake: ch_valid[k] and acc_valid are single-cycle pulses that
// qualify ch_data[k] and acc_data/acc_ch in the same cycle. There is no
// ready input; the consumer must capture on the pulse.
module tdm_demux_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int PIPE_LAT   = 2,
    parameter int BURST_LEN  = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sof,
    input  logic [DATA_WIDTH-1:0]                din,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_data,
    output logic [NUM_CH-1:0]                    ch_valid,
    output logic [ACC_WIDTH-1:0]                 acc_data,
    output logic [$clog2(NUM_CH)-1:0]            acc_ch,
    output logic                                 acc_valid,
    output logic                                 sat,
    output logic                                 sync_err,
    output logic [1:0]                           state_dbg
);

    localparam int CW = $clog2(NUM_CH);
    localparam int BW = $clog2(BURST_LEN);
    localparam int FW = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                      state;
    logic [FW-1:0]               fill_cnt;
    // slot_in holds the channel the mux presented in the previous cycle
    logic [CW-1:0]               slot_in;
    logic [PIPE_LAT-1:0]         tag_v;
    logic [PIPE_LAT-1:0][CW-1:0] tag_s;

    logic [ACC_WIDTH-1:0]        acc [NUM_CH];
    logic [BW-1:0]               cnt [NUM_CH];

    logic                        running;
    logic                        slot_wrap;
    logic [CW-1:0]               cur_slot;
    logic                        cur_v;
    logic                        misalign;
    logic                        ex_v;
    logic [CW-1:0]               ex_s;
    logic [ACC_WIDTH-1:0]        acc_base;
    logic [ACC_WIDTH:0]          sum_full;
    logic [ACC_WIDTH-1:0]        sum_sat;
    logic                        sum_ovf;
    logic                        burst_last;

    assign state_dbg = state;

    // Slot tracking for the mux-side channel and the exiting tag/accumulate math
    always_comb begin
        running   = (state != IDLE);
        slot_wrap = (slot_in == CW'(NUM_CH - 1));
        cur_v     = sof || running;
        if (sof || slot_wrap) begin
            cur_slot = '0;
        end else begin
            cur_slot = slot_in + 1'b1;
        end
        misalign  = sof && running && !slot_wrap;

        ex_v = tag_v[PIPE_LAT-1];
        ex_s = tag_s[PIPE_LAT-1];

        // First sample of a burst starts from zero instead of the old sum
        acc_base   = (cnt[ex_s] == '0) ? '0 : acc[ex_s];
        sum_full   = {1'b0, acc_base} + (ACC_WIDTH + 1)'(din);
        sum_ovf    = sum_full[ACC_WIDTH];
        sum_sat    = sum_ovf ? '1 : sum_full[ACC_WIDTH-1:0];
        burst_last = (cnt[ex_s] == BW'(BURST_LEN - 1));
    end

    // FSM, slot counter, tag delay line and sync error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fill_cnt <= '0;
            slot_in  <= '0;
            tag_v    <= '0;
            tag_s    <= '0;
            sync_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sof) begin
                        fill_cnt <= '0;
                        state    <= (PIPE_LAT == 1) ? RUN : FILL;
                    end
                end
                FILL: begin
                    if (fill_cnt == FW'(PIPE_LAT - 2)) begin
                        state <= RUN;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: state <= IDLE;
            endcase

            if (cur_v) begin
                slot_in <= cur_slot;
            end

            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_s[i] <= tag_s[i-1];
            end
            tag_v[0] <= cur_v;
            tag_s[0] <= cur_slot;

            if (misalign) begin
                sync_err <= 1'b1;
            end
        end
    end

    // De-interleave, per-channel burst accumulation and burst-complete output
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_data   <= '0;
            ch_valid  <= '0;
            acc_data  <= '0;
            acc_ch    <= '0;
            acc_valid <= 1'b0;
            sat       <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= '0;
                cnt[k] <= '0;
            end
        end else begin
            ch_valid  <= '0;
            acc_valid <= 1'b0;
            if (ex_v) begin
                ch_data[ex_s]  <= din;
                ch_valid[ex_s] <= 1'b1;
                acc[ex_s]      <= sum_sat;
                if (sum_ovf) begin
                    sat <= 1'b1;
                end
                if (burst_last) begin
                    cnt[ex_s] <= '0;
                    acc_data  <= sum_sat;
                    acc_ch    <= ex_s;
                    acc_valid <= 1'b1;
                end else begin
                    cnt[ex_s] <= cnt[ex_s] + 1'b1;
                end
            end
        end
    end

endmodule
